// File: rtl/mccu_pkg.sv
// Shared types and helpers for the MCCU interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: slot_state_t (per-core FSM states), calc_id_w (width of a core index).
package mccu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    RELOAD = 2'd2,
    BLANK  = 2'd3
  } slot_state_t;

  // Width of a core index, never less than one bit so a single-core build
  // still has a legal irq_id_o port.
  function automatic int calc_id_w(input int n_cores);
    int w;
    w = $clog2(n_cores);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mccu_irq_slot.sv
// Per-core interrupt slot: rising-edge capture, sticky pending/overflow, clear with optional quota reload.
// Latency: pending one cycle after the capturing edge; reload pulse one cycle after the clear.
// Backpressure: none; clear is a single-cycle write-1-to-clear and the reload pulse is fire-and-forget.
// Ports: clk, rst_n (async active-low); enable, irq_level, clear, reload_en, reload_value in;
//        pending, overflow, update_quota, quota out (quota is zero outside the reload pulse).
module mccu_irq_slot
  import mccu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  irq_level,
  input  logic                  clear,
  input  logic                  reload_en,
  input  logic [DATA_WIDTH-1:0] reload_value,
  output logic                  pending,
  output logic                  overflow,
  output logic                  update_quota,
  output logic [DATA_WIDTH-1:0] quota
);

  slot_state_t           state_q, state_d;
  logic                  prev_q;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] rld_q, rld_d;
  logic                  rise;

  // prev follows the level every cycle, even while disabled, so a level that
  // was already high when enable returns is not mistaken for a new event.
  assign rise = irq_level & ~prev_q & enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rld_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= irq_level;
      ovf_q   <= ovf_d;
      rld_q   <= rld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    rld_d   = rld_q;
    case (state_q)
      IDLE: begin
        if (rise) state_d = PEND;
      end
      PEND: begin
        if (clear) begin
          ovf_d = 1'b0;
          // A fresh edge arriving with the clear keeps the slot pending so
          // the new event is not lost; overflow stays cleared in that case.
          if (!rise) begin
            state_d = reload_en ? RELOAD : IDLE;
            rld_d   = reload_value;
          end
        end else if (rise) begin
          ovf_d = 1'b1;
        end
      end
      RELOAD: begin
        state_d = BLANK;
      end
      BLANK: begin
        // The MCCU level may still reflect the old quota this cycle, so edges
        // are ignored; a level still high here (e.g. zero reload) re-arms.
        state_d = (irq_level && enable) ? PEND : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pending      = (state_q == PEND);
  assign overflow     = ovf_q;
  assign update_quota = (state_q == RELOAD);
  assign quota        = update_quota ? rld_q : '0;

endmodule

// File: rtl/mccu_irq_ctrl.sv
// MCCU interrupt controller: N_CORES independent slots plus masked OR and lowest-index priority encoder.
// Latency: pending/irq one cycle after the quota edge; irq_o/irq_id_o combinational from pending_o and mask_i.
// Backpressure: none; every core's reload pulse is issued unconditionally, several may fire together.
// Ports: clk_i, rstn_i; enable_i, interruption_quota_i, mask_i, clear_i, reload_en_i, reload_value_i in;
//        pending_o, overflow_o, irq_o, irq_id_o, update_quota_o, quota_o out.
module mccu_irq_ctrl
  import mccu_pkg::*;
#(
  parameter int N_CORES    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_W       = calc_id_w(N_CORES)
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic                                enable_i,
  input  logic [N_CORES-1:0]                  interruption_quota_i,
  input  logic [N_CORES-1:0]                  mask_i,
  input  logic [N_CORES-1:0]                  clear_i,
  input  logic                                reload_en_i,
  input  logic [N_CORES-1:0][DATA_WIDTH-1:0]  reload_value_i,
  output logic [N_CORES-1:0]                  pending_o,
  output logic [N_CORES-1:0]                  overflow_o,
  output logic                                irq_o,
  output logic [ID_W-1:0]                     irq_id_o,
  output logic [N_CORES-1:0]                  update_quota_o,
  output logic [N_CORES-1:0][DATA_WIDTH-1:0]  quota_o
);

  logic [N_CORES-1:0] masked;

  for (genvar k = 0; k < N_CORES; k++) begin : g_slot
    mccu_irq_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk          (clk_i),
      .rst_n        (rstn_i),
      .enable       (enable_i),
      .irq_level    (interruption_quota_i[k]),
      .clear        (clear_i[k]),
      .reload_en    (reload_en_i),
      .reload_value (reload_value_i[k]),
      .pending      (pending_o[k]),
      .overflow     (overflow_o[k]),
      .update_quota (update_quota_o[k]),
      .quota        (quota_o[k])
    );
  end

  assign masked = pending_o & ~mask_i;
  assign irq_o  = |masked;

  // Scan from the top down so the lowest pending index is written last and wins.
  always_comb begin
    irq_id_o = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (masked[i]) irq_id_o = ID_W'(i);
    end
  end

endmodule

// File: tb/tb_mccu_irq_ctrl.sv
module tb_mccu_irq_ctrl;

  logic             clk_i;
  logic             rstn_i;
  logic             enable_i;
  logic [3:0]       interruption_quota_i;
  logic [3:0]       mask_i;
  logic [3:0]       clear_i;
  logic             reload_en_i;
  logic [3:0][31:0] reload_value_i;
  logic [3:0]       pending_o;
  logic [3:0]       overflow_o;
  logic             irq_o;
  logic [1:0]       irq_id_o;
  logic [3:0]       update_quota_o;
  logic [3:0][31:0] quota_o;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0]   pend;
    logic [3:0]   ovf;
    logic         irq;
    logic [1:0]   id;
    logic [3:0]   upd;
    logic [127:0] quota;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  mccu_irq_ctrl #(
    .N_CORES   (4),
    .DATA_WIDTH(32),
    .ID_W      (2)
  ) dut (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .enable_i            (enable_i),
    .interruption_quota_i(interruption_quota_i),
    .mask_i              (mask_i),
    .clear_i             (clear_i),
    .reload_en_i         (reload_en_i),
    .reload_value_i      (reload_value_i),
    .pending_o           (pending_o),
    .overflow_o          (overflow_o),
    .irq_o               (irq_o),
    .irq_id_o            (irq_id_o),
    .update_quota_o      (update_quota_o),
    .quota_o             (quota_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic cmp(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected irq/id are derived here from the expected pending set and the
  // mask currently being driven.
  task automatic push(input string tag, input logic [3:0] p, input logic [3:0] o,
                      input logic [3:0] u, input logic [127:0] q);
    exp_t       e;
    logic [3:0] m;
    m       = p & ~mask_i;
    e.pend  = p;
    e.ovf   = o;
    e.upd   = u;
    e.quota = q;
    e.irq   = |m;
    e.id    = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) e.id = 2'(i);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_pop();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    cmp({t, ".pending"},  128'(pending_o),      128'(e.pend));
    cmp({t, ".overflow"}, 128'(overflow_o),     128'(e.ovf));
    cmp({t, ".irq"},      128'(irq_o),          128'(e.irq));
    cmp({t, ".irq_id"},   128'(irq_id_o),       128'(e.id));
    cmp({t, ".update"},   128'(update_quota_o), 128'(e.upd));
    cmp({t, ".quota"},    128'(quota_o),        e.quota);
  endtask

  // Inputs are driven just after a falling edge; outputs are checked at the
  // next falling edge, i.e. half a cycle after the rising edge they depend on.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
    check_pop();
  endtask

  task automatic check_now();
    #1;
    check_pop();
  endtask

  function automatic logic [127:0] qv(input logic [31:0] q3, input logic [31:0] q2,
                                      input logic [31:0] q1, input logic [31:0] q0);
    return {q3, q2, q1, q0};
  endfunction

  initial begin
    rstn_i               = 1'b0;
    enable_i             = 1'b0;
    interruption_quota_i = '0;
    mask_i               = '0;
    clear_i              = '0;
    reload_en_i          = 1'b0;
    reload_value_i       = '0;

    // Reset state
    @(negedge clk_i);
    push("reset", 4'b0000, 4'b0000, 4'b0000, '0);
    check_now();
    @(negedge clk_i);
    rstn_i   = 1'b1;
    enable_i = 1'b1;
    push("idle", 4'b0000, 4'b0000, 4'b0000, '0);
    step();

    // Scenario 1: core 2 rises
    interruption_quota_i = 4'b0100;
    push("s1_capture", 4'b0100, 4'b0000, 4'b0000, '0);
    step();
    clear_i = 4'b0100;
    push("s1_clear", 4'b0000, 4'b0000, 4'b0000, '0);
    step();
    // Level still high but no new edge; clear outside PEND does nothing
    push("clear_in_idle", 4'b0000, 4'b0000, 4'b0000, '0);
    step();
    clear_i              = '0;
    interruption_quota_i = '0;
    push("s1_drop", 4'b0000, 4'b0000, 4'b0000, '0);
    step();

    // Scenario 2: cores 1 and 3, mask, clear
    interruption_quota_i = 4'b1010;
    push("s2_both", 4'b1010, 4'b0000, 4'b0000, '0);
    step();
    mask_i = 4'b0010;
    push("s2_masked", 4'b1010, 4'b0000, 4'b0000, '0);
    step();
    clear_i = 4'b1000;
    push("s2_clear3", 4'b0010, 4'b0000, 4'b0000, '0);
    step();
    clear_i              = '0;
    mask_i               = '0;
    interruption_quota_i = '0;
    push("s2_unmask", 4'b0010, 4'b0000, 4'b0000, '0);
    step();
    clear_i = 4'b0010;
    push("s2_clear1", 4'b0000, 4'b0000, 4'b0000, '0);
    step();
    clear_i = '0;

    // Enable low blocks capture
    enable_i             = 1'b0;
    interruption_quota_i = 4'b0001;
    push("disabled", 4'b0000, 4'b0000, 4'b0000, '0);
    step();
    enable_i             = 1'b1;
    interruption_quota_i = '0;
    push("reenable", 4'b0000, 4'b0000, 4'b0000, '0);
    step();

    // Scenario 3: reload core 0 with 150
    interruption_quota_i = 4'b0001;
    push("s3_capture", 4'b0001, 4'b0000, 4'b0000, '0);
    step();
    interruption_quota_i = '0;
    clear_i              = 4'b0001;
    reload_en_i          = 1'b1;
    reload_value_i[0]    = 32'd150;
    push("s3_reload", 4'b0000, 4'b0000, 4'b0001, qv(0, 0, 0, 150));
    step();
    clear_i           = '0;
    reload_value_i[0] = 32'd999;
    push("s3_blank", 4'b0000, 4'b0000, 4'b0000, '0);
    step();
    push("s3_idle", 4'b0000, 4'b0000, 4'b0000, '0);
    step();
    reload_en_i = 1'b0;

    // Scenario 4: overflow on core 1
    interruption_quota_i = 4'b0010;
    push("s4_capture", 4'b0010, 4'b0000, 4'b0000, '0);
    step();
    interruption_quota_i = '0;
    push("s4_low", 4'b0010, 4'b0000, 4'b0000, '0);
    step();
    interruption_quota_i = 4'b0010;
    push("s4_overflow", 4'b0010, 4'b0010, 4'b0000, '0);
    step();
    clear_i = 4'b0010;
    push("s4_clear", 4'b0000, 4'b0000, 4'b0000, '0);
    step();
    clear_i              = '0;
    interruption_quota_i = '0;
    push("s4_drop", 4'b0000, 4'b0000, 4'b0000, '0);
    step();

    // Scenario 5: edge coinciding with clear on core 2, then zero reload
    interruption_quota_i = 4'b0100;
    push("s5_capture", 4'b0100, 4'b0000, 4'b0000, '0);
    step();
    interruption_quota_i = '0;
    push("s5_low", 4'b0100, 4'b0000, 4'b0000, '0);
    step();
    interruption_quota_i = 4'b0100;
    push("s5_overflow", 4'b0100, 4'b0100, 4'b0000, '0);
    step();
    interruption_quota_i = '0;
    push("s5_low2", 4'b0100, 4'b0100, 4'b0000, '0);
    step();
    interruption_quota_i = 4'b0100;
    clear_i              = 4'b0100;
    reload_en_i          = 1'b1;
    reload_value_i[2]    = 32'd0;
    push("s5_edge_wins", 4'b0100, 4'b0000, 4'b0000, '0);
    step();
    push("s5_zero_reload", 4'b0000, 4'b0000, 4'b0100, '0);
    step();
    clear_i = '0;
    push("s5_blank", 4'b0000, 4'b0000, 4'b0000, '0);
    step();
    push("s5_rearm", 4'b0100, 4'b0000, 4'b0000, '0);
    step();
    clear_i              = 4'b0100;
    reload_en_i          = 1'b0;
    interruption_quota_i = '0;
    push("s5_clear", 4'b0000, 4'b0000, 4'b0000, '0);
    step();
    clear_i = '0;

    // Simultaneous reloads on cores 0 and 3
    interruption_quota_i = 4'b1001;
    push("multi_capture", 4'b1001, 4'b0000, 4'b0000, '0);
    step();
    interruption_quota_i = '0;
    clear_i              = 4'b1001;
    reload_en_i          = 1'b1;
    reload_value_i[0]    = 32'd11;
    reload_value_i[3]    = 32'd33;
    push("multi_reload", 4'b0000, 4'b0000, 4'b1001, qv(33, 0, 0, 11));
    step();
    clear_i = '0;
    push("multi_blank", 4'b0000, 4'b0000, 4'b0000, '0);
    step();

    // Scenario 6: asynchronous reset during RELOAD
    interruption_quota_i = 4'b0001;
    push("s6_capture", 4'b0001, 4'b0000, 4'b0000, '0);
    step();
    interruption_quota_i = '0;
    clear_i              = 4'b0001;
    reload_value_i[0]    = 32'd77;
    push("s6_reload", 4'b0000, 4'b0000, 4'b0001, qv(0, 0, 0, 77));
    step();
    clear_i = '0;
    rstn_i  = 1'b0;
    push("s6_async_reset", 4'b0000, 4'b0000, 4'b0000, '0);
    check_now();

    // A level already high at reset release counts as an edge
    @(negedge clk_i);
    interruption_quota_i = 4'b0010;
    reload_en_i          = 1'b0;
    rstn_i               = 1'b1;
    push("release_edge", 4'b0010, 4'b0000, 4'b0000, '0);
    step();

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mccu_irq_ctrl.md
MCCU_IRQ_CTRL -- requirements
Module: mccu_irq_ctrl

Interface
REQ-001 The block SHALL have parameter N_CORES, default 4, meaning the number of supervised cores.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the quota width.
REQ-003 The block SHALL have parameter ID_W, default max(1,$clog2(N_CORES)), meaning the irq_id_o width.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-006 rstn_i  in  1  asynchronous active-low reset.
REQ-007 enable_i  in  1  gates new interrupt capture.
REQ-008 interruption_quota_i  in  N_CORES  per-core quota-exhausted level from the MCCU.
REQ-009 mask_i  in  N_CORES  1 = core excluded from irq_o and irq_id_o.
REQ-010 clear_i  in  N_CORES  single-cycle write-1-to-clear of pending and overflow.
REQ-011 reload_en_i  in  1  clear also reloads the MCCU quota.
REQ-012 reload_value_i  in  N_CORES x DATA_WIDTH  per-core reload quota.
REQ-013 pending_o  out  N_CORES  sticky per-core pending flags.
REQ-014 overflow_o  out  N_CORES  sticky flag for an interrupt edge while already pending.
REQ-015 irq_o  out  1  OR of (pending_o & ~mask_i).
REQ-016 irq_id_o  out  ID_W  lowest index of (pending_o & ~mask_i); 0 when none.
REQ-017 update_quota_o  out  N_CORES  one-cycle pulse to the MCCU update_quota_i.
REQ-018 quota_o  out  N_CORES x DATA_WIDTH  quota value to the MCCU quota_i, valid with update_quota_o.

Function
REQ-019 Each core SHALL keep a registered copy of the previous interruption_quota_i level (prev) and a per-core FSM with states IDLE, PEND, RELOAD and BLANK.
REQ-020 An edge SHALL be defined as interruption_quota_i[k]=1 and prev[k]=0 and enable_i=1; prev SHALL update every cycle regardless of enable_i.
REQ-021 The IDLE state SHALL move to PEND on an edge; pending_o[k] SHALL be 1 from the cycle after the capturing clock edge.
REQ-022 The PEND state SHALL move to RELOAD on clear_i[k] with reload_en_i=1, and to IDLE on clear_i[k] with reload_en_i=0; overflow_o[k] SHALL be cleared in both cases.
REQ-023 An edge in the same cycle as clear_i[k] in PEND SHALL win: the state stays PEND, pending stays 1, and overflow_o[k] is cleared and not set.
REQ-024 An edge in PEND without a clear SHALL set overflow_o[k].
REQ-025 In RELOAD, update_quota_o[k] SHALL be 1 and quota_o[k] SHALL equal reload_value_i[k] sampled at the clear edge, for exactly one cycle; pending_o[k] SHALL be 0; the state SHALL then move to BLANK.
REQ-026 In BLANK (one cycle), edges SHALL be ignored; the state SHALL move to PEND if interruption_quota_i[k]=1 and enable_i=1, otherwise to IDLE, so a zero reload re-arms.
REQ-027 clear_i[k] outside PEND SHALL have no effect.
REQ-028 When enable_i=0, no PEND entry SHALL occur, but clears and reloads SHALL still complete.
REQ-029 Cores SHALL operate independently; simultaneous clears of several cores SHALL reload them in the same cycle.
REQ-030 irq_o and irq_id_o SHALL be combinational from registered pending_o and mask_i.
REQ-031 quota_o[k] SHALL be 0 whenever update_quota_o[k]=0.

Reset
REQ-032 On rstn_i=0, all FSMs SHALL go to IDLE, and prev, pending_o, overflow_o, update_quota_o and quota_o SHALL go to 0, asynchronously.
REQ-033 A reset during RELOAD SHALL drop update_quota_o immediately.
REQ-034 interruption_quota_i=1 at reset release SHALL be captured as an edge on the first enabled cycle, matching the MCCU zero quota after reset.

Structure
REQ-035 The package mccu_pkg SHALL hold the slot-state enum (IDLE/PEND/RELOAD/BLANK) and the ID_W computation function.
REQ-036 The per-core FSM, prev, pending, overflow and reload registers SHALL be the sub-module mccu_irq_slot, instantiated N_CORES times.
REQ-037 The top level SHALL add only the priority encoder and the irq OR.

Verification (N_CORES=4, DATA_WIDTH=32)
REQ-038 Scenario 1: interruption_quota_i[2] rises, enable_i=1, mask_i=0 -> next cycle pending_o=4'b0100, irq_o=1, irq_id_o=2.
REQ-039 Scenario 2: cores 1 and 3 pending, mask_i=4'b0010 -> irq_id_o=3; clear_i[3] -> irq_o=0 next cycle.
REQ-040 Scenario 3: core 0 pending, clear_i[0] with reload_en_i=1 and reload_value_i[0]=150 -> next cycle update_quota_o[0]=1 and quota_o[0]=150 for one cycle; interrupt low -> IDLE after BLANK.
REQ-041 Scenario 4: a second rise on core 1 while pending -> overflow_o[1]=1; clear_i[1] -> pending_o[1]=0 and overflow_o[1]=0.
REQ-042 Scenario 5: clear_i[2] coincides with an edge on core 2 -> pending_o[2] stays 1 and overflow_o[2]=0; with reload_value_i=0 and the interrupt held high -> PEND re-entered after BLANK.
REQ-043 Scenario 6: rstn_i asserted during RELOAD -> update_quota_o=0 without a clock edge, and all outputs are 0.
